fwd_ctrl_unit: RTL and testbench



---
 rtl/fwd_pkg.sv | 46 ++++
 rtl/dest_track_stage.sv | 36 +++
 rtl/fwd_ctrl_unit.sv | 98 +++++++++
 tb/tb_fwd_ctrl_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_pkg
//  Description : Shared select codes, tracking-entry type and select priority
//                for the EX-stage forwarding control. FWD_WB_HOLD_EN enables
//                the WB-hold (code 11) forwarding path.
//  Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    localparam int C_REG_AW = 5;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EXMEM  = 2'b01;
    localparam logic [1:0] FWD_MEMWB  = 2'b10;
    localparam logic [1:0] FWD_WBHOLD = 2'b11;

    typedef struct packed {
        logic                v;
        logic [C_REG_AW-1:0] rd;
        logic                rw;
        logic                ld;
    } dest_entry_t;

    // Youngest producer wins; a WB producer without the hold path is
    // covered by the regfile's internal write bypass.
    function automatic logic [1:0] fwd_select(input logic hit_ex,
                                              input logic hit_mem,
                                              input logic hit_wb);
        if (hit_ex)
            return FWD_EXMEM;
        else if (hit_mem)
            return FWD_MEMWB;
`ifdef FWD_WB_HOLD_EN
        else if (hit_wb)
            return FWD_WBHOLD;
`else
        else if (hit_wb)
            return FWD_RF;
`endif
        else
            return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dest_track_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dest_track_stage
//  Description : One destination-tracking entry with producer-match compares
//                against two source registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module dest_track_stage
    import fwd_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  dest_entry_t         i_d,
    input  logic [C_REG_AW-1:0] i_rs1,
    input  logic [C_REG_AW-1:0] i_rs2,
    output dest_entry_t         o_q,
    output logic                o_hit_rs1,
    output logic                o_hit_rs2
);

    dest_entry_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= '0;
        else
            r_q <= i_d;
    end

    // x0 is hardwired to zero, so it never has a producer.
    assign o_hit_rs1 = r_q.v & r_q.rw & (r_q.rd == i_rs1) & (i_rs1 != '0);
    assign o_hit_rs2 = r_q.v & r_q.rw & (r_q.rd == i_rs2) & (i_rs2 != '0);
    assign o_q       = r_q;

endmodule
`default_nettype wire

// File: rtl/fwd_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_ctrl_unit
//  Description : EX-stage operand forwarding selects and load-use stall,
//                driven from an EX/MEM/WB(/HOLD) destination-tracking chain.
//                FWD_WB_HOLD_EN keeps the HOLD entry and emits code 11.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_ctrl_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b
);

    dest_entry_t w_id_entry;
    dest_entry_t w_ex_d;
    dest_entry_t w_ex_q;
    dest_entry_t w_mem_q;
    dest_entry_t w_wb_q;
    logic        w_ex_hit1,  w_ex_hit2;
    logic        w_mem_hit1, w_mem_hit2;
    logic        w_wb_hit1,  w_wb_hit2;
    logic        w_bubble;
    logic [SEL_W-1:0] r_sel_a;
    logic [SEL_W-1:0] r_sel_b;

    assign w_id_entry = '{v: id_valid, rd: id_rd, rw: id_regwrite, ld: id_memread};

    // A load in EX feeding ID cannot be forwarded in time: hold ID one cycle.
    assign stall    = id_valid & ~ex_flush & w_ex_q.ld & (w_ex_hit1 | w_ex_hit2);
    assign w_bubble = stall | ex_flush | ~id_valid;
    assign w_ex_d   = w_bubble ? '0 : w_id_entry;

    dest_track_stage u_ex (
        .clk(clk), .rst(rst), .i_d(w_ex_d), .i_rs1(id_rs1), .i_rs2(id_rs2),
        .o_q(w_ex_q), .o_hit_rs1(w_ex_hit1), .o_hit_rs2(w_ex_hit2)
    );

    dest_track_stage u_mem (
        .clk(clk), .rst(rst), .i_d(w_ex_q), .i_rs1(id_rs1), .i_rs2(id_rs2),
        .o_q(w_mem_q), .o_hit_rs1(w_mem_hit1), .o_hit_rs2(w_mem_hit2)
    );

    dest_track_stage u_wb (
        .clk(clk), .rst(rst), .i_d(w_mem_q), .i_rs1(id_rs1), .i_rs2(id_rs2),
        .o_q(w_wb_q), .o_hit_rs1(w_wb_hit1), .o_hit_rs2(w_wb_hit2)
    );

`ifdef FWD_WB_HOLD_EN
    // HOLD mirrors the WB-hold data register beside the EX mux; its
    // compares are never consulted because its producer has retired.
    dest_entry_t w_hold_q;
    logic        w_hold_hit1, w_hold_hit2;
    logic        w_unused_hold;

    dest_track_stage u_hold (
        .clk(clk), .rst(rst), .i_d(w_wb_q), .i_rs1(id_rs1), .i_rs2(id_rs2),
        .o_q(w_hold_q), .o_hit_rs1(w_hold_hit1), .o_hit_rs2(w_hold_hit2)
    );

    assign w_unused_hold = ^{w_hold_q, w_hold_hit1, w_hold_hit2};
`else
    logic w_unused_wb;
    assign w_unused_wb = ^w_wb_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_a <= FWD_RF;
            r_sel_b <= FWD_RF;
        end else if (w_bubble) begin
            r_sel_a <= FWD_RF;
            r_sel_b <= FWD_RF;
        end else begin
            r_sel_a <= fwd_select(w_ex_hit1, w_mem_hit1, w_wb_hit1);
            r_sel_b <= fwd_select(w_ex_hit2, w_mem_hit2, w_wb_hit2);
        end
    end

    assign fwd_sel_a = r_sel_a;
    assign fwd_sel_b = r_sel_b;

endmodule
`default_nettype wire

// File: tb/tb_fwd_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_ctrl_unit
//  Description : Self-checking bench for fwd_ctrl_unit: an instruction-stream
//                vector table plus a mid-stream reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_regwrite, id_memread, ex_flush;
    logic       stall;
    logic [1:0] fwd_sel_a, fwd_sel_b;

    fwd_ctrl_unit #(.REG_AW(5), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .ex_flush(ex_flush), .stall(stall),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
    );

    always #5 clk = ~clk;

`ifdef FWD_WB_HOLD_EN
    localparam logic [1:0] WBX = 2'b11;
`else
    localparam logic [1:0] WBX = 2'b00;
`endif

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld, fl;
        logic       exp_stall;
        logic [1:0] exp_a, exp_b;
    } vec_t;

    typedef struct {
        logic [1:0] a, b;
        int         idx;
    } sel_exp_t;

    vec_t     vecs[23];
    sel_exp_t sb_q[$];
    int       n_vec  = 0;
    int       n_fail = 0;

    task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic ld, input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = ld; ex_flush = fl;
    endtask

    task automatic pop_check();
        sel_exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL scoreboard: queue empty, got a=%b b=%b, expected an entry", fwd_sel_a, fwd_sel_b);
        end else begin
            e = sb_q.pop_front();
            check("fwd_sel_a", e.idx, fwd_sel_a, e.a);
            check("fwd_sel_b", e.idx, fwd_sel_b, e.b);
        end
    endtask

    initial begin
        //                v  rs1 rs2 rd rw ld fl  stall a      b
        vecs[0]  = '{1'b1, 5'd1,  5'd2,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // add x5
        vecs[1]  = '{1'b1, 5'd5,  5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00}; // add x6,x5,x1
        vecs[2]  = '{1'b1, 5'd3,  5'd4,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // add x5
        vecs[3]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // nop
        vecs[4]  = '{1'b1, 5'd2,  5'd5,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10}; // sub x7,x2,x5
        vecs[5]  = '{1'b1, 5'd5,  5'd0,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, WBX,   2'b00}; // x5 now in WB
        vecs[6]  = '{1'b1, 5'd1,  5'd2,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // add x0
        vecs[7]  = '{1'b1, 5'd0,  5'd0,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // add x3,x0,x0
        vecs[8]  = '{1'b1, 5'd1,  5'd0,  5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00}; // lw x8
        vecs[9]  = '{1'b1, 5'd8,  5'd8,  5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00}; // load-use
        vecs[10] = '{1'b1, 5'd8,  5'd8,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10}; // replayed
        vecs[11] = '{1'b1, 5'd2,  5'd3,  5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00}; // lw x8
        vecs[12] = '{1'b1, 5'd8,  5'd8,  5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00}; // flushed
        vecs[13] = '{1'b1, 5'd9,  5'd8,  5'd13, 1'b1, 1'b0, 1'b0, 1'b0, WBX,   2'b10}; // x9 WB, x8 MEM
        vecs[14] = '{1'b1, 5'd1,  5'd2,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // add x4
        vecs[15] = '{1'b1, 5'd4,  5'd3,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00}; // add x4,x4,x3
        vecs[16] = '{1'b1, 5'd4,  5'd4,  5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01}; // two x4 writers
        vecs[17] = '{1'b1, 5'd14, 5'd4,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10}; // store-like
        vecs[18] = '{1'b1, 5'd5,  5'd20, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // rd5 rw=0
        vecs[19] = '{1'b1, 5'd1,  5'd2,  5'd21, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00}; // lw x21
        vecs[20] = '{1'b0, 5'd21, 5'd21, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00}; // invalid ID
        vecs[21] = '{1'b1, 5'd1,  5'd21, 5'd22, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10}; // add x22
        vecs[22] = '{1'b1, 5'd22, 5'd0,  5'd23, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00}; // lw x23,0(x22)

        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset stall", -1, {1'b0, stall}, 2'b00);
        check("reset fwd_sel_a", -1, fwd_sel_a, 2'b00);
        check("reset fwd_sel_b", -1, fwd_sel_b, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].fl);
            sb_q.push_back('{a: vecs[i].exp_a, b: vecs[i].exp_b, idx: i});
            #1;
            check("stall", i, {1'b0, stall}, {1'b0, vecs[i].exp_stall});
            @(posedge clk);
            #1;
            pop_check();
        end

        // Load x23 sits in EX; a dependent add stalls until reset hits.
        @(negedge clk);
        drive(1'b1, 5'd23, 5'd23, 5'd24, 1'b1, 1'b0, 1'b0);
        #1;
        check("pre-reset stall", 100, {1'b0, stall}, 2'b01);
        rst = 1'b1;
        #1;
        check("mid-reset stall", 101, {1'b0, stall}, 2'b00);
        check("mid-reset fwd_sel_a", 101, fwd_sel_a, 2'b00);
        check("mid-reset fwd_sel_b", 101, fwd_sel_b, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{a: 2'b00, b: 2'b00, idx: 102});
        #1;
        check("post-reset stall", 102, {1'b0, stall}, 2'b00);
        @(posedge clk);
        #1;
        pop_check();

        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        if (sb_q.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
